// File: rtl/tc_if.sv
// Data-memory bus bundle between the MEM stage/bridge and the countdown timer.
interface tc_if;
  logic [31:0] A;
  logic [31:0] WD;
  logic [3:0]  be;
  logic        Wr;
  logic [31:0] DR;
  logic        IRQ;

  modport master (output A, output WD, output be, output Wr, input DR, input IRQ);
  modport slave  (input A, input WD, input be, input Wr, output DR, output IRQ);
endinterface

// File: rtl/tc.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot and
// auto-reload modes, interrupt request masked by CTRL.IM.
module tc (
  input  logic clk,
  input  logic rst,
  tc_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [1:0]  state;
  logic        irq_flag;

  logic        en;
  logic        auto_reload;
  logic        sel_ctrl;
  logic        sel_preset;
  logic        unused_a;

  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign sel_ctrl    = bus.Wr && (bus.A[3:2] == 2'd0);
  assign sel_preset  = bus.Wr && (bus.A[3:2] == 2'd1);
  assign unused_a    = ^{bus.A[31:4], bus.A[1:0]};

  // Byte-lane merge: enabled lanes take store data, others keep old value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  // CTRL: FSM clears Enable at end of one-shot; a same-cycle CPU store wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl <= 4'd0;
    end else begin
      if (state == S_INT && !auto_reload) ctrl[0] <= 1'b0;
      if (sel_ctrl && bus.be[0]) ctrl <= bus.WD[3:0];
    end
  end

  // PRESET: plain byte-enabled register, sampled by the FSM only in LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preset <= 32'd0;
    end else if (sel_preset) begin
      preset <= lane_merge(preset, bus.WD, bus.be);
    end
  end

  // Counter FSM with COUNT and irq_flag; FSM set of irq_flag overrides a CTRL-store clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      if (sel_ctrl) irq_flag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) state <= S_LOAD;
        end
        S_LOAD: begin
          if (!en) begin
            state <= S_IDLE;
          end else begin
            count <= preset;
            state <= S_CNT;
          end
        end
        S_CNT: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= 32'd0;
            irq_flag <= 1'b1;
            state    <= S_INT;
          end
        end
        default: begin
          if (auto_reload) begin
            irq_flag <= 1'b0;
            state    <= en ? S_LOAD : S_IDLE;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Read mux: zero-wait-state loads decoded from A[3:2].
  always_comb begin
    bus.DR = 32'd0;
    case (bus.A[3:2])
      2'd0:    bus.DR = {28'd0, ctrl};
      2'd1:    bus.DR = preset;
      2'd2:    bus.DR = count;
      default: bus.DR = 32'd0;
    endcase
  end

  assign bus.IRQ = irq_flag & ctrl[3];

endmodule
